music_sequencer: RTL and testbench

//  Parametrised successor to the fixed-tune music player. It plays a score held in an

---
 rtl/music_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_music_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer: plays a writable score of {half_period, dur} entries as a
// square wave on one speaker pin, with start/stop/loop control, an optional
// silent gap after each entry, and busy/done/note_idx status.
module music_sequencer #(
    parameter int TICK_DIV  = 1200000,
    parameter int DEPTH     = 64,
    parameter int HALF_W    = 16,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [HALF_W+DUR_W-1:0] wr_data,
    input  logic [AW:0]             len,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop,
    output logic                    busy,
    output logic                    done,
    output logic [AW-1:0]           note_idx,
    output logic                    speaker
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0]     TICK_ONE  = 1;
    localparam logic [GW-1:0]     GAP_INIT  = GW'(GAP_TICKS);
    localparam logic [GW-1:0]     GAP_ONE   = 1;
    localparam logic [HALF_W-1:0] HALF_ONE  = 1;
    localparam logic [DUR_W-1:0]  DUR_ONE   = 1;
    localparam logic [AW:0]       IDX_ONE   = 1;
    localparam logic [AW:0]       DEPTH_L   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                speaker_q, speaker_d;
    logic [AW-1:0]       note_idx_q, note_idx_d;
    logic [AW:0]         len_q, len_d;
    logic                load_cnt_q, load_cnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [HALF_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]    dur_left_q, dur_left_d;
    logic [GW-1:0]       gap_left_q, gap_left_d;

    logic [HALF_W+DUR_W-1:0] mem [DEPTH];
    logic [HALF_W+DUR_W-1:0] rd_data_q;
    logic [HALF_W-1:0]       rd_half;
    logic [DUR_W-1:0]        rd_dur;
    logic [AW:0]             nxt_idx;
    logic                    last_entry;
    logic                    advance;

    assign rd_half    = rd_data_q[HALF_W+DUR_W-1:DUR_W];
    assign rd_dur     = rd_data_q[DUR_W-1:0];
    assign nxt_idx    = {1'b0, note_idx_q} + IDX_ONE;
    assign last_entry = (nxt_idx >= len_q);

    // Score RAM: writes only while idle; synchronous read of the current entry.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[note_idx_q];
    end

    // Control state and counters; asynchronous clear silences the pin at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            speaker_q  <= 1'b0;
            note_idx_q <= '0;
            len_q      <= '0;
            load_cnt_q <= 1'b0;
            half_q     <= '0;
            tone_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_left_q <= '0;
            gap_left_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            speaker_q  <= speaker_d;
            note_idx_q <= note_idx_d;
            len_q      <= len_d;
            load_cnt_q <= load_cnt_d;
            half_q     <= half_d;
            tone_cnt_q <= tone_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_left_q <= dur_left_d;
            gap_left_q <= gap_left_d;
        end
    end

    // Next-state: per-state sequencing, then the shared advance step, then stop override.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        speaker_d  = speaker_q;
        note_idx_d = note_idx_q;
        len_d      = len_q;
        load_cnt_d = load_cnt_q;
        half_d     = half_q;
        tone_cnt_d = tone_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_left_d = dur_left_q;
        gap_left_d = gap_left_q;
        advance    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (len != '0)) begin
                    state_d    = S_LOAD;
                    busy_d     = 1'b1;
                    note_idx_d = '0;
                    load_cnt_d = 1'b0;
                    len_d      = (len > DEPTH_L) ? DEPTH_L : len;
                end
            end

            S_LOAD: begin
                // First cycle addresses the RAM, second cycle sees its registered data.
                if (!load_cnt_q) begin
                    load_cnt_d = 1'b1;
                end else begin
                    load_cnt_d = 1'b0;
                    if (rd_dur == '0) begin
                        advance = 1'b1;
                    end else begin
                        state_d    = S_PLAY;
                        half_d     = rd_half;
                        tone_cnt_d = '0;
                        tick_cnt_d = '0;
                        dur_left_d = rd_dur;
                        speaker_d  = 1'b0;
                    end
                end
            end

            S_PLAY: begin
                if (half_q == '0) begin
                    speaker_d  = 1'b0;
                    tone_cnt_d = '0;
                end else if (tone_cnt_q == (half_q - HALF_ONE)) begin
                    speaker_d  = ~speaker_q;
                    tone_cnt_d = '0;
                end else begin
                    tone_cnt_d = tone_cnt_q + HALF_ONE;
                end

                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (dur_left_q == DUR_ONE) begin
                        dur_left_d = '0;
                        speaker_d  = 1'b0;
                        tone_cnt_d = '0;
                        if (GAP_TICKS > 0) begin
                            state_d    = S_GAP;
                            gap_left_d = GAP_INIT;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        dur_left_d = dur_left_q - DUR_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end

            S_GAP: begin
                speaker_d = 1'b0;
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    if (gap_left_q == GAP_ONE) begin
                        gap_left_d = '0;
                        advance    = 1'b1;
                    end else begin
                        gap_left_d = gap_left_q - GAP_ONE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + TICK_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (advance) begin
            speaker_d  = 1'b0;
            load_cnt_d = 1'b0;
            if (!last_entry) begin
                note_idx_d = nxt_idx[AW-1:0];
                state_d    = S_LOAD;
            end else if (loop) begin
                note_idx_d = '0;
                state_d    = S_LOAD;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            speaker_d  = 1'b0;
            load_cnt_d = 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;
    assign speaker  = speaker_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer with a small tick so whole scores fit in a few hundred cycles.
// Expected per-cycle output traces are built from the score timing and queued before playback.
module tb_music_sequencer;

    localparam int TICK  = 4;
    localparam int DEPTH = 8;
    localparam int HW    = 8;
    localparam int DW    = 4;
    localparam int GAP   = 1;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [11:0]   wr_data;
    logic [3:0]    len;
    logic          start;
    logic          stop;
    logic          loop;
    logic          busy;
    logic          done;
    logic [2:0]    note_idx;
    logic          speaker;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       spk;
        logic       chk_idx;
        logic [2:0] idx;
    } exp_t;

    exp_t  sb[$];
    int    checks;
    int    errors;
    string tag;

    music_sequencer #(
        .TICK_DIV (TICK),
        .DEPTH    (DEPTH),
        .HALF_W   (HW),
        .DUR_W    (DW),
        .GAP_TICKS(GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .busy    (busy),
        .done    (done),
        .note_idx(note_idx),
        .speaker (speaker)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic b, input logic d, input logic s, input logic c, input logic [2:0] ix);
        exp_t e;
        e.busy    = b;
        e.done    = d;
        e.spk     = s;
        e.chk_idx = c;
        e.idx     = ix;
        sb.push_back(e);
    endtask

    // One score entry: 2 LOAD cycles, then dur*TICK tone cycles and GAP*TICK silent cycles.
    task automatic push_entry(input logic [2:0] ix, input int half, input int dur);
        logic s;
        for (int k = 0; k < 2; k++) push(1'b1, 1'b0, 1'b0, 1'b1, ix);
        if (dur != 0) begin
            for (int k = 0; k < dur * TICK; k++) begin
                s = (half != 0) && (((k / half) % 2) == 1);
                push(1'b1, 1'b0, s, 1'b1, ix);
            end
            for (int k = 0; k < GAP * TICK; k++) push(1'b1, 1'b0, 1'b0, 1'b1, ix);
        end
    endtask

    task automatic push_done();
        push(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) push(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] h, input logic [3:0] d);
        wr_addr = a;
        wr_data = {h, d};
        wr_en   = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic kick(input logic [3:0] l);
        len   = l;
        start = 1'b1;
    endtask

    // Pops one expectation per clock; optional stop (with a write) and loop-drop points.
    task automatic check_trace(input int stop_at, input int drop_at);
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            exp_t       e;
            logic [5:0] obs;
            logic [5:0] expv;
            @(posedge clk);
            #1;
            if (i == 0) start = 1'b0;
            e    = sb.pop_front();
            obs  = {busy, done, speaker, (e.chk_idx ? note_idx : 3'd0)};
            expv = {e.busy, e.done, e.spk, (e.chk_idx ? e.idx : 3'd0)};
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s cycle %0d: busy/done/spk/idx got %b required %b", tag, i, obs, expv);
            end
            if (i == stop_at) begin
                stop  = 1'b1;
                wr_en = 1'b1;
            end
            if (i == stop_at + 1) begin
                stop  = 1'b0;
                wr_en = 1'b0;
            end
            if (i == drop_at) loop = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] obs;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;

        // 1: reset values and no activity without start
        repeat (3) @(posedge clk);
        #1;
        obs = {busy, done, speaker, note_idx};
        checks++;
        assert (obs === 6'b0) else begin
            errors++;
            $error("FAIL reset_hold: busy/done/spk/idx got %b required %b", obs, 6'b0);
        end
        rst = 1'b1;
        tag = "idle_after_reset";
        for (int k = 0; k < 6; k++) push(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        check_trace(-1, -1);

        // 2: two-entry score, tone then rest, ends with a single done pulse
        wr(3'd0, 8'd3, 4'd2);
        wr(3'd1, 8'd0, 4'd1);
        tag = "play_two";
        kick(4'd2);
        push_entry(3'd0, 3, 2);
        push_entry(3'd1, 0, 1);
        push_done();
        check_trace(-1, -1);

        // 3: loop for two passes, loop dropped mid second pass
        tag  = "loop";
        loop = 1'b1;
        kick(4'd2);
        push_entry(3'd0, 3, 2);
        push_entry(3'd1, 0, 1);
        push_entry(3'd0, 3, 2);
        push_entry(3'd1, 0, 1);
        push_done();
        check_trace(-1, 30);

        // 4: stop three clocks into PLAY, a write during busy is dropped
        tag     = "stop";
        wr_addr = 3'd0;
        wr_data = {8'd9, 4'd1};
        kick(4'd2);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        push_idle(4);
        check_trace(5, -1);
        tag = "replay_after_drop";
        kick(4'd2);
        push_entry(3'd0, 3, 2);
        push_entry(3'd1, 0, 1);
        push_done();
        check_trace(-1, -1);

        // 5: zero-duration entry is skipped; len=0 start is ignored
        wr(3'd0, 8'd5, 4'd0);
        wr(3'd1, 8'd2, 4'd1);
        tag = "skip_dur0";
        kick(4'd2);
        push_entry(3'd0, 5, 0);
        push_entry(3'd1, 2, 1);
        push_done();
        check_trace(-1, -1);
        tag = "len_zero";
        kick(4'd0);
        push_idle(5);
        check_trace(-1, -1);

        // 6: asynchronous reset while the speaker is high
        wr(3'd0, 8'd3, 4'd2);
        tag = "pre_reset";
        kick(4'd1);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
        check_trace(-1, -1);
        #2;
        rst = 1'b0;
        #1;
        obs = {busy, done, speaker, note_idx};
        checks++;
        assert (obs === 6'b0) else begin
            errors++;
            $error("FAIL async_reset: busy/done/spk/idx got %b required %b", obs, 6'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tag = "idle_after_async";
        push_idle(4);
        check_trace(-1, -1);
        wr(3'd0, 8'd2, 4'd1);
        tag = "restart_after_reset";
        kick(4'd1);
        push_entry(3'd0, 2, 1);
        push_done();
        check_trace(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
